adxl357_sample_avg: RTL and testbench
=====================================

ADXL357_SAMPLE_AVG -- requirements
Module: adxl357_sample_avg

Interface
- REQ-001 SHALL have parameter AVG_LOG2_MAX, default 4, meaning the largest allowed log2 block length (max 16 samples).
- REQ-002 SHALL have i_clk, input, 1, single system clock (50 MHz).
- REQ-003 SHALL have i_rst, input, 1, asynchronous active-high reset.
- REQ-004 SHALL have i_acc_x, i_acc_y, i_acc_z, input, 32 each, signed 20-bit acceleration sign-extended to 32, from the I2C controller.
- REQ-005 SHALL have i_temp, input, 32, unsigned 12-bit temperature zero-extended to 32.
- REQ-006 SHALL have i_done, input, 1, controller finish flag, asynchronous to this block; data inputs are stable from its falling edge until the next transaction.
- REQ-007 SHALL have i_cfg, input, 32: [0] enable; [3:1] avg_log2; [4] clear; other bits ignored.
- REQ-008 SHALL have o_acc_x, o_acc_y, o_acc_z, output, 32 each, signed block averages.
- REQ-009 SHALL have o_temp, output, 32, unsigned block-average temperature.
- REQ-010 SHALL have o_valid, output, 1, one-cycle pulse marking new averages.
- REQ-011 SHALL have o_status, output, 32: [0] enable; [5:1] sample count in current block; [7:6] FSM state; [15:8] completed-block counter; [31:16] zero.

Function
- REQ-012 SHALL pass i_done through a 2-flop synchronizer plus one history flop; a sample event is synchronized-high followed by synchronized-low.
- REQ-013 SHALL implement FSM IDLE(0) -> CAPT(1) -> ACCUM(2) -> OUT(3) -> IDLE.
  - IDLE->CAPT on a sample event with enable=1.
  - CAPT->ACCUM unconditionally.
  - ACCUM->OUT when the count reaches 2^len, else ACCUM->IDLE.
- REQ-014 SHALL ignore sample events while enable=0, leaving the accumulators and count untouched.
- REQ-015 SHALL, in CAPT, latch all four data inputs into hold registers.
- REQ-016 SHALL, in ACCUM, add the held values to 32-bit signed accumulators (temperature accumulator unsigned) and increment the count.
- REQ-017 SHALL latch len = min(avg_log2, AVG_LOG2_MAX) only when count=0, so avg_log2 changes mid-block take effect at the next block.
- REQ-018 SHALL, in OUT, compute each acceleration output as its accumulator arithmetic-shifted right by len (floor toward minus infinity), and o_temp as its accumulator logically shifted right by len.
- REQ-019 SHALL, in OUT, pulse o_valid for exactly one cycle, zero the accumulators and count, and increment the block counter modulo 256.
- REQ-020 SHALL produce a pipeline in which, counting the first i_clk edge that samples i_done=0 as edge 1, the capture occurs at edge 3, the accumulate at edge 4, and o_valid is high after edge 5 when the block completes.
- REQ-021 SHALL hold o_acc_x/y/z and o_temp between o_valid pulses.
- REQ-022 SHALL, when clear=1, zero the accumulators and count, force IDLE, and suppress o_valid, while leaving the outputs and block counter unchanged; a sample event while clear=1 SHALL be dropped.
- REQ-023 SHALL, if enable falls mid-block, finish any in-flight CAPT/ACCUM/OUT and retain the partial accumulation until enable returns or clear is applied.
- REQ-024 SHALL produce no overflow for the maximum block of 16 samples of +/-2^19 (sum within +/-2^23).

Reset
- REQ-025 SHALL, while i_rst=1 asynchronously, set the synchronizer flops to 0, FSM to IDLE, accumulators, hold registers, count, len, block counter, o_acc_x/y/z, o_temp, o_valid and o_status[31:1] to 0.
- REQ-026 SHALL abandon any partial block on reset assertion mid-operation; after release, the first sample event starts a new block.

Verification
- REQ-027 SHALL cover pass-through: avg_log2=0, enable=1, x=100, y=-5, z=0x7FFFF, temp=1000, one i_done pulse -> o_valid at edge 5 with outputs 100, -5, 524287, 1000, and o_status[15:8]=1.
- REQ-028 SHALL cover flooring: avg_log2=2, x = -3,-2,-1,-1 and temp = 1000,1001,1002,1003 -> exactly one o_valid after the 4th event with o_acc_x=-2 and o_temp=1001, and no o_valid on events 1-3.
- REQ-029 SHALL cover extremes: avg_log2=4, 16 samples each with x=-524288 and y=524287 -> o_acc_x=-524288, o_acc_y=524287, and avg_log2=7 behaves identically to 4.
- REQ-030 SHALL cover clear and enable: avg_log2=2 with two samples, then a one-cycle clear, then four samples of x=8 -> o_acc_x=8; events while enable=0 produce no count change.
- REQ-031 SHALL cover mid-block config change and reset: avg_log2 changed from 2 to 0 after sample 1 -> the block still completes after 4 samples; i_rst pulsed after sample 3 -> all outputs 0, and the next single event under avg_log2=0 yields o_valid.

Source files
------------

// File: rtl/adxl357_sample_avg.sv
// adxl357_sample_avg
// Block averager for ADXL357 samples delivered by the I2C controller.
// Each falling edge of i_done (after synchronization) captures one X/Y/Z/temp
// sample and adds it to the running sums. When 2^len samples have been summed,
// the averages are published with a one-cycle o_valid pulse.
//
// Ports
//   i_clk                  system clock
//   i_rst                  asynchronous active-high reset
//   i_acc_x/y/z [31:0]     signed 20-bit acceleration, sign-extended
//   i_temp      [31:0]     unsigned 12-bit temperature, zero-extended
//   i_done                 controller finish flag (asynchronous)
//   i_cfg       [31:0]     [0] enable, [3:1] avg_log2, [4] clear
//   o_acc_x/y/z [31:0]     signed block averages
//   o_temp      [31:0]     unsigned block-average temperature
//   o_valid                one-cycle pulse on new averages
//   o_status    [31:0]     [0] enable, [5:1] count, [7:6] state, [15:8] blocks
//
// State | meaning
// IDLE  | waiting for a sample event; hold registers load on leaving
// CAPT  | sample held; sums and count update on leaving
// ACCUM | sums current; publish averages on leaving if the block is full
// OUT   | averages just published; return to IDLE
//
// AVG_LOG2_MAX must stay in 0..4 (count field is 5 bits).

module adxl357_sample_avg #(
    parameter int AVG_LOG2_MAX = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_acc_x,
    input  logic [31:0] i_acc_y,
    input  logic [31:0] i_acc_z,
    input  logic [31:0] i_temp,
    input  logic        i_done,
    input  logic [31:0] i_cfg,
    output logic [31:0] o_acc_x,
    output logic [31:0] o_acc_y,
    output logic [31:0] o_acc_z,
    output logic [31:0] o_temp,
    output logic        o_valid,
    output logic [31:0] o_status
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CAPT  = 2'd1,
        ACCUM = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam logic [2:0] LEN_MAX = 3'(AVG_LOG2_MAX);

    state_t state, state_nxt;

    logic        done_s1, done_s2, done_h;
    logic        sample_evt;
    logic        cfg_en, cfg_clr;
    logic [2:0]  cfg_log2, len_cap, len;
    logic [4:0]  count;
    logic [7:0]  blk_cnt;
    logic        block_full;
    logic        capt_go, accum_go, out_go;

    logic signed [31:0] hold_x, hold_y, hold_z;
    logic        [31:0] hold_t;
    logic signed [31:0] acc_x, acc_y, acc_z;
    logic        [31:0] acc_t;

    logic unused_cfg;
    assign unused_cfg = ^i_cfg[31:5];

    assign cfg_en   = i_cfg[0];
    assign cfg_log2 = i_cfg[3:1];
    assign cfg_clr  = i_cfg[4];
    assign len_cap  = (cfg_log2 > LEN_MAX) ? LEN_MAX : cfg_log2;

    // Event = synchronized flag was high last cycle and is low now.
    assign sample_evt = done_h & ~done_s2;
    assign block_full = (count == (5'd1 << len));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            done_s1 <= 1'b0;
            done_s2 <= 1'b0;
            done_h  <= 1'b0;
        end else begin
            done_s1 <= i_done;
            done_s2 <= done_s1;
            done_h  <= done_s2;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Enable only gates the start of a sample; a sample already in flight
    // completes even if enable drops. Clear overrides everything.
    always_comb begin
        state_nxt = state;
        capt_go   = 1'b0;
        accum_go  = 1'b0;
        out_go    = 1'b0;
        if (cfg_clr) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (sample_evt && cfg_en) begin
                        state_nxt = CAPT;
                        capt_go   = 1'b1;
                    end
                end
                CAPT: begin
                    state_nxt = ACCUM;
                    accum_go  = 1'b1;
                end
                ACCUM: begin
                    if (block_full) begin
                        state_nxt = OUT;
                        out_go    = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hold_x  <= '0;
            hold_y  <= '0;
            hold_z  <= '0;
            hold_t  <= '0;
            acc_x   <= '0;
            acc_y   <= '0;
            acc_z   <= '0;
            acc_t   <= '0;
            count   <= '0;
            len     <= '0;
            blk_cnt <= '0;
            o_acc_x <= '0;
            o_acc_y <= '0;
            o_acc_z <= '0;
            o_temp  <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= out_go;
            // Block length is frozen once the first sample of a block lands.
            if (count == 5'd0) begin
                len <= len_cap;
            end
            if (cfg_clr) begin
                acc_x <= '0;
                acc_y <= '0;
                acc_z <= '0;
                acc_t <= '0;
                count <= '0;
            end else begin
                if (capt_go) begin
                    hold_x <= i_acc_x;
                    hold_y <= i_acc_y;
                    hold_z <= i_acc_z;
                    hold_t <= i_temp;
                end
                if (accum_go) begin
                    acc_x <= acc_x + hold_x;
                    acc_y <= acc_y + hold_y;
                    acc_z <= acc_z + hold_z;
                    acc_t <= acc_t + hold_t;
                    count <= count + 5'd1;
                end
                if (out_go) begin
                    o_acc_x <= acc_x >>> len;
                    o_acc_y <= acc_y >>> len;
                    o_acc_z <= acc_z >>> len;
                    o_temp  <= acc_t >> len;
                    acc_x   <= '0;
                    acc_y   <= '0;
                    acc_z   <= '0;
                    acc_t   <= '0;
                    count   <= '0;
                    blk_cnt <= blk_cnt + 8'd1;
                end
            end
        end
    end

    assign o_status = {16'd0, blk_cnt, state, count, cfg_en};

endmodule

// File: tb/tb_adxl357_sample_avg.sv
module tb_adxl357_sample_avg;

    logic        i_clk;
    logic        i_rst;
    logic [31:0] i_acc_x, i_acc_y, i_acc_z, i_temp;
    logic        i_done;
    logic [31:0] i_cfg;
    logic [31:0] o_acc_x, o_acc_y, o_acc_z, o_temp;
    logic        o_valid;
    logic [31:0] o_status;

    adxl357_sample_avg #(.AVG_LOG2_MAX(4)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_acc_x  (i_acc_x),
        .i_acc_y  (i_acc_y),
        .i_acc_z  (i_acc_z),
        .i_temp   (i_temp),
        .i_done   (i_done),
        .i_cfg    (i_cfg),
        .o_acc_x  (o_acc_x),
        .o_acc_y  (o_acc_y),
        .o_acc_z  (o_acc_z),
        .o_temp   (o_temp),
        .o_valid  (o_valid),
        .o_status (o_status)
    );

    initial i_clk = 1'b0;
    always #10 i_clk = ~i_clk;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic [31:0] t;
        logic [7:0]  blk;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input int x, input int y, input int z, input int t, input int blk);
        exp_t p;
        p.x   = 32'(x);
        p.y   = 32'(y);
        p.z   = 32'(z);
        p.t   = 32'(t);
        p.blk = 8'(blk);
        sb.push_back(p);
    endtask

    task automatic set_cfg(input logic [31:0] c);
        @(negedge i_clk);
        i_cfg = c;
    endtask

    task automatic sample(input int x, input int y, input int z, input int t);
        @(negedge i_clk);
        i_acc_x = 32'(x);
        i_acc_y = 32'(y);
        i_acc_z = 32'(z);
        i_temp  = 32'(t);
        i_done  = 1'b1;
        repeat (3) @(negedge i_clk);
        i_done = 1'b0;
        repeat (8) @(negedge i_clk);
    endtask

    function automatic logic [31:0] st_count(input logic [31:0] s);
        return (s >> 1) & 32'h1F;
    endfunction

    // Scoreboard consumer: every o_valid must match the oldest expected block.
    always @(negedge i_clk) begin
        if (!i_rst && o_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("avg_x", o_acc_x, e.x);
                chk("avg_y", o_acc_y, e.y);
                chk("avg_z", o_acc_z, e.z);
                chk("avg_t", o_temp, e.t);
                chk("blk_cnt", 32'(o_status[15:8]), 32'(e.blk));
            end
        end
    end

    initial begin
        i_rst   = 1'b1;
        i_done  = 1'b0;
        i_cfg   = 32'd0;
        i_acc_x = '0;
        i_acc_y = '0;
        i_acc_z = '0;
        i_temp  = '0;
        repeat (3) @(negedge i_clk);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_x", o_acc_x, 32'd0);
        chk("rst_temp", o_temp, 32'd0);
        chk("rst_status", o_status, 32'd0);
        i_rst = 1'b0;
        repeat (3) @(negedge i_clk);

        // Pass-through with exact latency: o_valid after the 5th edge.
        set_cfg(32'h1);
        push_exp(100, -5, 524287, 1000, 1);
        @(negedge i_clk);
        i_acc_x = 32'd100;
        i_acc_y = -32'sd5;
        i_acc_z = 32'h7FFFF;
        i_temp  = 32'd1000;
        i_done  = 1'b1;
        repeat (3) @(negedge i_clk);
        i_done = 1'b0;
        repeat (4) @(negedge i_clk);
        chk("lat_edge4", 32'(o_valid), 32'd0);
        @(negedge i_clk);
        chk("lat_edge5", 32'(o_valid), 32'd1);
        @(negedge i_clk);
        chk("valid_one_cycle", 32'(o_valid), 32'd0);
        repeat (6) @(negedge i_clk);

        // Flooring: mean -1.75 floors to -2; temp 1001.5 floors to 1001.
        set_cfg(32'h5);
        sample(-3, 0, 0, 1000);
        sample(-2, 0, 0, 1001);
        sample(-1, 0, 0, 1002);
        chk("floor_count3", st_count(o_status), 32'd3);
        push_exp(-2, 0, 0, 1001, 2);
        sample(-1, 0, 0, 1003);
        chk("hold_x", o_acc_x, -32'sd2);

        // Extremes over 16 samples, then avg_log2=7 clamped to 4.
        set_cfg(32'h9);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) push_exp(-524288, 524287, 0, 4095, 3);
            sample(-524288, 524287, 0, 4095);
        end
        set_cfg(32'hF);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) push_exp(-524288, 524287, 0, 4095, 4);
            sample(-524288, 524287, 0, 4095);
        end

        // Disabled events, clear, then a fresh block of x=8.
        set_cfg(32'h5);
        sample(5, 0, 0, 0);
        sample(5, 0, 0, 0);
        chk("count_before_dis", st_count(o_status), 32'd2);
        set_cfg(32'h4);
        sample(99, 0, 0, 0);
        chk("count_disabled", st_count(o_status), 32'd2);
        chk("en_bit_low", o_status & 32'h1, 32'd0);
        set_cfg(32'h15);
        set_cfg(32'h5);
        chk("count_cleared", st_count(o_status), 32'd0);
        chk("clear_keeps_x", o_acc_x, 32'hFFF80000);
        chk("clear_keeps_blk", 32'(o_status[15:8]), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) push_exp(8, 0, 0, 0, 5);
            sample(8, 0, 0, 0);
        end

        // avg_log2 change mid-block is deferred to the next block.
        sample(4, 0, 0, 0);
        set_cfg(32'h1);
        sample(4, 0, 0, 0);
        chk("midcfg_count2", st_count(o_status), 32'd2);
        sample(4, 0, 0, 0);
        push_exp(4, 0, 0, 0, 6);
        sample(4, 0, 0, 0);

        // Reset mid-block, then a single-sample block.
        set_cfg(32'h5);
        sample(1, 1, 1, 1);
        sample(1, 1, 1, 1);
        sample(1, 1, 1, 1);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("mrst_x", o_acc_x, 32'd0);
        chk("mrst_y", o_acc_y, 32'd0);
        chk("mrst_z", o_acc_z, 32'd0);
        chk("mrst_temp", o_temp, 32'd0);
        chk("mrst_status", o_status & 32'hFFFFFFFE, 32'd0);
        i_rst = 1'b0;
        set_cfg(32'h1);
        push_exp(77, -1, 3, 12, 1);
        sample(77, -1, 3, 12);

        repeat (4) @(negedge i_clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
